// File: rtl/sdram_to_bram_reader.sv
// DMA read engine: pulls a block of 256-bit beats from HPS SDRAM over AXI3 and
// writes them sequentially into FPGA block RAM, one burst outstanding at a time.
module sdram_to_bram_reader #(
  parameter int BRAM_AW   = 10,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [31:0]        addr,
  input  logic [BRAM_AW:0]   len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        araddr,
  output logic [3:0]         arlen,
  output logic [7:0]         arid,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic [1:0]         arlock,
  output logic [2:0]         arprot,
  output logic [3:0]         arcache,
  output logic               arvalid,
  input  logic               arready,
  input  logic [255:0]       rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic [7:0]         rid,
  input  logic               rvalid,
  output logic               rready,
  output logic               bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [255:0]       bram_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          cur_addr_q, cur_addr_d;
  logic [BRAM_AW:0]     remaining_q, remaining_d;
  logic [4:0]           burst_n_q, burst_n_d;
  logic [4:0]           beat_cnt_q, beat_cnt_d;
  logic [BRAM_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic                 err_q, err_d;
  logic                 bram_we_q, bram_we_d;
  logic [BRAM_AW-1:0]   bram_addr_q, bram_addr_d;
  logic [255:0]         bram_wdata_q, bram_wdata_d;
  logic [31:0]          araddr_q, araddr_d;
  logic [3:0]           arlen_q, arlen_d;

  logic [31:0]          next_addr;
  logic [BRAM_AW:0]     next_rem;
  logic [4:0]           n_calc;
  logic                 unused_rid;

  // Beats in the next burst: capped by MAX_BURST, what is left, and the 4 KB page end.
  function automatic logic [4:0] calc_burst(input logic [31:0] a, input logic [BRAM_AW:0] rem);
    int unsigned n;
    int unsigned to_4k;
    to_4k = 32'd128 - 32'(a[11:5]);
    n = 32'(MAX_BURST);
    if (32'(rem) < n) n = 32'(rem);
    if (to_4k < n) n = to_4k;
    return 5'(n);
  endfunction

  assign arid       = 8'd0;
  assign arsize     = 3'b101;
  assign arburst    = 2'b01;
  assign arlock     = 2'b00;
  assign arprot     = 3'b000;
  assign arcache    = 4'b0011;
  assign unused_rid = ^rid;

  assign arvalid    = (state_q == S_ADDR);
  assign rready     = (state_q == S_DATA);
  assign busy       = (state_q == S_ADDR) || (state_q == S_DATA);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign araddr     = araddr_q;
  assign arlen      = arlen_q;
  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;

  assign next_addr  = cur_addr_q + {22'd0, burst_n_q, 5'd0};
  assign next_rem   = remaining_q - (BRAM_AW+1)'(burst_n_q);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    burst_n_d    = burst_n_q;
    beat_cnt_d   = beat_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    err_d        = err_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    n_calc       = 5'd0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            n_calc      = calc_burst(addr, len);
            cur_addr_d  = addr;
            remaining_d = len;
            wr_ptr_d    = '0;
            bram_addr_d = '0;
            burst_n_d   = n_calc;
            araddr_d    = addr;
            arlen_d     = 4'(n_calc - 5'd1);
            state_d     = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        if (arready) begin
          beat_cnt_d = 5'd0;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (rvalid) begin
          if (beat_cnt_q < burst_n_q) begin
            bram_we_d    = 1'b1;
            bram_addr_d  = wr_ptr_q;
            bram_wdata_d = rdata;
            wr_ptr_d     = wr_ptr_q + BRAM_AW'(1);
            beat_cnt_d   = beat_cnt_q + 5'd1;
          end else begin
            err_d = 1'b1;
          end
          if (rresp != 2'b00) err_d = 1'b1;
          // A short or long burst still retires the full n so the address plan stays fixed.
          if (rlast) begin
            if (beat_cnt_q + 5'd1 != burst_n_q) err_d = 1'b1;
            cur_addr_d  = next_addr;
            remaining_d = next_rem;
            if (next_rem != '0) begin
              n_calc    = calc_burst(next_addr, next_rem);
              burst_n_d = n_calc;
              araddr_d  = next_addr;
              arlen_d   = 4'(n_calc - 5'd1);
              state_d   = S_ADDR;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      burst_n_q    <= '0;
      beat_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      err_q        <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      burst_n_q    <= burst_n_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      err_q        <= err_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
    end
  end

endmodule

// File: tb/tb_sdram_to_bram_reader.sv
// Randomized bench: an AXI3 read slave backed by a synthetic memory, and a
// transfer-level model giving the expected AR list, BRAM writes and error flag.
module tb_sdram_to_bram_reader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [31:0]  addr;
  logic [10:0]  len;
  logic         busy, done, err;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [7:0]   arid;
  logic [2:0]   arsize;
  logic [1:0]   arburst, arlock;
  logic [2:0]   arprot;
  logic [3:0]   arcache;
  logic         arvalid, arready;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic [7:0]   rid;
  logic         rvalid, rready;
  logic         bram_we;
  logic [9:0]   bram_addr;
  logic [255:0] bram_wdata;

  sdram_to_bram_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arid(arid), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arprot(arprot), .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          cnt;
  } burst_t;

  int n_vec = 0;
  int n_err = 0;

  // slave configuration and state
  int          ar_stall, r_stall, inj_resp, inj_burst, inj_beats;
  logic [31:0] salt;
  burst_t      bq[$];
  int          r_beat, r_gbeat, ar_idx;
  logic        ar_pend;
  logic [31:0] ar_hold_a;
  logic [3:0]  ar_hold_l;
  int          stab_bad;

  // observed logs
  logic [35:0]  ar_log[$];
  logic [265:0] wr_log[$];
  int           done_cnt, busy_gap;
  logic         err_at_done, we_at_done, busy_at_done, in_xfer;

  // expected results
  logic [35:0]  exp_ar[$];
  logic [265:0] exp_wr[$];
  logic         exp_err;

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] mem_word(input logic [31:0] a);
    logic [255:0] w;
    for (int k = 0; k < 8; k++)
      w[k*32 +: 32] = (a * 32'h9E3779B1) ^ (32'(k) * 32'h01010101) ^ salt;
    return w;
  endfunction

  // AXI3 read slave, driven on the falling edge
  initial begin
    burst_t bt;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 8'd0;
    ar_pend = 1'b0; r_beat = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bq.delete(); r_beat = 0; ar_pend = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else begin
        if (arvalid) begin
          if (ar_pend && (araddr !== ar_hold_a || arlen !== ar_hold_l)) stab_bad++;
          ar_hold_a = araddr; ar_hold_l = arlen; ar_pend = 1'b1;
          arready = ($urandom_range(99) >= 32'(ar_stall));
          if (arready) begin
            bt.addr = araddr;
            bt.cnt  = (ar_idx == inj_burst) ? inj_beats : int'(arlen) + 1;
            bq.push_back(bt);
            ar_log.push_back({araddr, arlen});
            ar_idx++;
            ar_pend = 1'b0;
          end
        end else begin
          arready = 1'($urandom_range(1));
          ar_pend = 1'b0;
        end
        rid = 8'($urandom);
        if (rready && bq.size() > 0 && $urandom_range(99) >= 32'(r_stall)) begin
          rvalid = 1'b1;
          rdata  = mem_word(bq[0].addr + 32'(r_beat * 32));
          rresp  = (r_gbeat == inj_resp) ? 2'b10 : 2'b00;
          rlast  = (r_beat == bq[0].cnt - 1);
          r_beat++;
          r_gbeat++;
          if (rlast) begin
            void'(bq.pop_front());
            r_beat = 0;
          end
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
          rdata  = mem_word($urandom);
        end
      end
    end
  end

  // output monitor
  initial begin
    in_xfer = 1'b0; done_cnt = 0; busy_gap = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_xfer = 1'b0;
      end else begin
        if (bram_we) wr_log.push_back({bram_addr, bram_wdata});
        if (busy) in_xfer = 1'b1;
        if (done) begin
          done_cnt++;
          err_at_done = err; we_at_done = bram_we; busy_at_done = busy;
          in_xfer = 1'b0;
        end else if (in_xfer && !busy) begin
          busy_gap++;
        end
      end
    end
  end

  task automatic start_xfer(input logic [31:0] a, input int l, input int ars, input int rs,
                            input int resp_idx, input int ib, input int ibeats);
    logic [31:0] ca;
    int r, n, t, d, g, b, wi;
    ar_stall = ars; r_stall = rs; inj_resp = resp_idx; inj_burst = ib; inj_beats = ibeats;
    salt = $urandom;
    r_gbeat = 0; ar_idx = 0; stab_bad = 0; busy_gap = 0; done_cnt = 0;
    ar_log.delete(); wr_log.delete(); exp_ar.delete(); exp_wr.delete();
    // expected plan: split on MAX_BURST and 4 KB pages, BRAM filled from word 0
    ca = a; r = l; g = 0; b = 0; wi = 0; exp_err = 1'b0;
    while (r > 0) begin
      n = (r < 16) ? r : 16;
      t = (4096 - int'(ca % 32'd4096)) / 32;
      if (t < n) n = t;
      exp_ar.push_back({ca, 4'(n - 1)});
      d = (b == ib) ? ibeats : n;
      if (d != n) exp_err = 1'b1;
      if (resp_idx >= g && resp_idx < g + d) exp_err = 1'b1;
      for (int j = 0; j < d && j < n; j++) begin
        exp_wr.push_back({10'(wi), mem_word(ca + 32'(j * 32))});
        wi++;
      end
      g += d; ca += 32'(n * 32); r -= n; b++;
    end
    @(negedge clk);
    start = 1'b1; addr = a; len = 11'(l);
    @(negedge clk);
    start = 1'b0; addr = $urandom; len = 11'($urandom);
    if (l > 0) check("t1_busy_arvalid_err_done", 300'({busy, arvalid, err, done}), 300'(4'b1100));
    else       check("t1_len0_done", 300'({busy, arvalid, err, done}), 300'(4'b0001));
  endtask

  task automatic finish_xfer(input string name);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_seen"}, 300'(done_cnt > 0), 300'(1));
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, 300'(done_cnt), 300'(1));
    check({name, "_err"}, 300'(err_at_done), 300'(exp_err));
    check({name, "_busy_at_done"}, 300'(busy_at_done), 300'(0));
    if (!exp_err && exp_wr.size() > 0) check({name, "_last_we_with_done"}, 300'(we_at_done), 300'(1));
    check({name, "_ar_count"}, 300'(ar_log.size()), 300'(exp_ar.size()));
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
      check({name, "_ar"}, 300'(ar_log[i]), 300'(exp_ar[i]));
    check({name, "_wr_count"}, 300'(wr_log.size()), 300'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      check({name, "_wr"}, 300'(wr_log[i]), 300'(exp_wr[i]));
    check({name, "_ar_stable"}, 300'(stab_bad), 300'(0));
    check({name, "_busy_gap"}, 300'(busy_gap), 300'(0));
    $display("xfer %s: %0d ARs, %0d writes, err=%0b", name, ar_log.size(), wr_log.size(), err_at_done);
  endtask

  task automatic run_xfer(input string name, input logic [31:0] a, input int l, input int ars,
                          input int rs, input int resp_idx, input int ib, input int ibeats);
    start_xfer(a, l, ars, rs, resp_idx, ib, ibeats);
    finish_xfer(name);
  endtask

  initial begin
    logic [31:0] ra;
    int cyc;
    reset_n = 1'b0; start = 1'b0; addr = '0; len = '0;
    ar_stall = 0; r_stall = 0; inj_resp = -1; inj_burst = -1; inj_beats = 0;
    salt = '0; r_gbeat = 0; ar_idx = 0; stab_bad = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 300'({arvalid, rready, busy, done, err, bram_we, bram_addr, bram_wdata, araddr, arlen}), 300'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 300'({arvalid, rready, busy, done, err, bram_we}), 300'(0));

    run_xfer("basic40",   32'h0000_1000, 40, 0, 0, -1, -1, 0);
    run_xfer("split4k",   32'h0000_0FC0, 4,  0, 0, -1, -1, 0);
    run_xfer("len0",      32'h0000_2000, 0,  0, 0, -1, -1, 0);
    run_xfer("stall33",   32'h0000_3F00, 33, 50, 50, -1, -1, 0);
    run_xfer("rresp_b3",  32'h0001_0000, 20, 20, 20, 3, -1, 0);
    run_xfer("early_last", 32'h0000_0000, 32, 0, 0, -1, 0, 5);
    run_xfer("after_err", 32'h0000_0400, 8,  0, 0, -1, -1, 0);
    run_xfer("extra_beats", 32'h0000_0800, 24, 10, 10, -1, 1, 10);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom & 32'hFFFF_FFE0;
      if (k % 2 == 0) ra[11:5] = 7'(120 + $urandom_range(7));
      run_xfer("random", ra, int'($urandom_range(80, 1)), int'($urandom_range(60)),
               int'($urandom_range(60)), -1, -1, 0);
    end
    run_xfer("full1024", 32'h0040_0020, 1024, 5, 5, -1, -1, 0);

    // reset while data is streaming, with err already raised
    start_xfer(32'h0000_2000, 40, 30, 30, 0, -1, 0);
    cyc = 0;
    while ((wr_log.size() < 3 || !rready) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_in_data", 300'(rready), 300'(1));
    check("rst_err_before", 300'(err), 300'(1));
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs", 300'({arvalid, rready, busy, done, err, bram_we, bram_addr, bram_wdata, araddr, arlen}), 300'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_xfer("post_reset", 32'h0000_5FE0, 30, 20, 20, -1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
